// File: rtl/dmem_arbiter.sv
// Port-B arbiter for the data memory: core MEM stage has default priority, the dbg master
// gets a guaranteed slot after a bounded number of blocked cycles.
module dmem_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_SIZE    = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_read,
    input  logic                 core_write,
    input  logic [ADDR_SIZE-1:0] core_addr,
    input  logic [WORD_SIZE-1:0] core_wdata,
    input  logic [1:0]           core_size,
    input  logic                 core_unsigned,
    output logic                 core_stall,
    output logic [WORD_SIZE-1:0] core_rdata,
    output logic                 core_rvalid,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [ADDR_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    input  logic [1:0]           dbg_size,
    input  logic                 dbg_unsigned,
    output logic                 dbg_ack,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    output logic                 b_en_read,
    output logic                 b_en_write,
    output logic [ADDR_SIZE-1:0] b_addr,
    output logic [WORD_SIZE-1:0] b_din,
    output logic [1:0]           b_size,
    output logic                 b_unsigned,
    input  logic [WORD_SIZE-1:0] b_dout
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_GO  = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {StCore, StDbg, StAck} state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  dbg_was_read;
    logic [WORD_SIZE-1:0]  dbg_rdata_q;
    logic                  core_req;
    logic                  dbg_own;
    logic                  core_rd_issue;

    assign core_req      = core_read | core_write;
    assign dbg_own       = (state == StDbg);
    // A simultaneous read+write from the core is a write; the read never issues.
    assign core_rd_issue = !dbg_own && core_read && !core_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StCore;
            wait_cnt     <= '0;
            dbg_was_read <= 1'b0;
            dbg_rdata_q  <= '0;
            core_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_rd_issue;
            case (state)
                StCore: begin
                    if (dbg_req && (!core_req || wait_cnt == CNT_GO)) begin
                        state    <= StDbg;
                        wait_cnt <= '0;
                    end else if (dbg_req && core_req && wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StDbg: begin
                    state        <= StAck;
                    dbg_was_read <= !dbg_we;
                end
                StAck: begin
                    state <= StCore;
                    if (dbg_was_read) begin
                        dbg_rdata_q <= b_dout;
                    end
                end
                default: state <= StCore;
            endcase
        end
    end

    always_comb begin
        b_en_read  = core_read & ~core_write;
        b_en_write = core_write;
        b_addr     = core_addr;
        b_din      = core_wdata;
        b_size     = core_size;
        b_unsigned = core_unsigned;
        if (dbg_own) begin
            b_en_read  = ~dbg_we;
            b_en_write = dbg_we;
            b_addr     = dbg_addr;
            b_din      = dbg_wdata;
            b_size     = dbg_size;
            b_unsigned = dbg_unsigned;
        end
        if (rst) begin
            b_en_read  = 1'b0;
            b_en_write = 1'b0;
        end
    end

    assign core_stall = dbg_own && core_req && !rst;
    assign core_rdata = b_dout;
    assign dbg_ack    = (state == StAck) && !rst;
    // Read data is forwarded during the ack cycle and held in the register afterwards.
    assign dbg_rdata  = (state == StAck && dbg_was_read && !rst) ? b_dout : dbg_rdata_q;

endmodule
